// File: rtl/adder_chk_pkg.sv
// Shared types and constants for the adder stimulus/checker block.
package adder_chk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SETTLE,
      ST_CHECK,
      ST_DONE
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Feedback taps at bits 15, 13, 12 and 10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [7:0]  ERR_MAX   = 8'hFF;

   function automatic logic lfsr_feedback(input logic [15:0] value);
      return ^(value & LFSR_TAPS);
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR operand source: seed load, advance enable, parallel output.
module lfsr16
   import adder_chk_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        adv,
   output logic [15:0] value
);

   always_ff @(posedge clk) begin
      if (rst || load) begin
         value <= LFSR_SEED;
      end else if (adv) begin
         value <= {value[14:0], lfsr_feedback(value)};
      end
   end

endmodule

// File: rtl/adder_stim_checker.sv
// Drives LFSR operand pairs to an adder datapath and counts mismatching sums.
// Optional first-failure capture is built when ADDER_CHK_FAIL_CAPTURE_EN is defined.
module adder_stim_checker
   import adder_chk_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SETTLE      = 2,
   parameter int NUM_VECTORS = 256
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   input  logic [WIDTH-1:0] sum_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [7:0]       err_count,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic [WIDTH-1:0] fail_sum
);

   localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_t           state;
   state_t           state_next;
   logic [15:0]      lfsr;
   logic             lfsr_load;
   logic             lfsr_adv;
   logic [WIDTH-1:0] expected;
   logic [SC_W-1:0]  settle_cnt;
   logic [15:0]      vec_cnt;
   logic             run_start;
   logic             mismatch;
   logic             last_vec;

   assign run_start = ((state == ST_IDLE) || (state == ST_DONE)) && start;
   assign mismatch  = (sum_in != expected);
   assign last_vec  = (vec_cnt == 16'(NUM_VECTORS - 1));

   lfsr16 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load  (lfsr_load),
      .adv   (lfsr_adv),
      .value (lfsr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      lfsr_load  = 1'b0;
      lfsr_adv   = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_next = ST_DRIVE;
               lfsr_load  = 1'b1;
            end
         end
         ST_DRIVE:  state_next = ST_SETTLE;
         ST_SETTLE: begin
            if (settle_cnt == '0) begin
               state_next = ST_CHECK;
            end
         end
         ST_CHECK: begin
            lfsr_adv   = 1'b1;
            state_next = last_vec ? ST_DONE : ST_DRIVE;
         end
         default:   state_next = ST_IDLE;
      endcase
   end

   // Operands, expected sum and counters; operands only move in DRIVE.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_out     <= '0;
         b_out     <= '0;
         err_count <= '0;
         vec_cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  vec_cnt   <= '0;
                  err_count <= '0;
               end
            end
            ST_DRIVE: begin
               a_out      <= lfsr[WIDTH-1:0];
               b_out      <= lfsr[8+WIDTH-1:8];
               expected   <= lfsr[WIDTH-1:0] + lfsr[8+WIDTH-1:8];
               settle_cnt <= SC_W'(SETTLE - 1);
            end
            ST_SETTLE: settle_cnt <= settle_cnt - 1'b1;
            ST_CHECK: begin
               if (mismatch && (err_count != ERR_MAX)) begin
                  err_count <= err_count + 8'd1;
               end
               if (!last_vec) begin
                  vec_cnt <= vec_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_CHECK);
   assign done = (state == ST_DONE);
   assign pass = done && (err_count == '0);

`ifdef ADDER_CHK_FAIL_CAPTURE_EN
   // err_count is still zero only on the first mismatch of a run.
   always_ff @(posedge clk) begin
      if (rst || run_start) begin
         fail_a   <= '0;
         fail_b   <= '0;
         fail_sum <= '0;
      end else if ((state == ST_CHECK) && mismatch && (err_count == '0)) begin
         fail_a   <= a_out;
         fail_b   <= b_out;
         fail_sum <= sum_in;
      end
   end
`else
   assign fail_a   = '0;
   assign fail_b   = '0;
   assign fail_sum = '0;
`endif

endmodule

// File: tb/tb_adder_stim_checker.sv
// Directed bench for adder_stim_checker: short runs against a selectable adder model plus a long saturation run.
module tb_adder_stim_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a_out, b_out, sum_in;
   logic       busy, done, pass;
   logic [7:0] err_count, fail_a, fail_b, fail_sum;

   logic       start2;
   logic [7:0] a2, b2, sum2;
   logic       busy2, done2, pass2;
   logic [7:0] err2, fa2, fb2, fs2;

   int checks   = 0;
   int failures = 0;
   int mode     = 0;   // 0 exact, 1 stuck 0x00, 2 latency SETTLE+1, 3 latency SETTLE+2
   logic [7:0] dl [0:2];

   always #5 clk = ~clk;

   // Latency counted from the edge that enters DRIVE: the operand register adds one cycle, dl[k-2] adds k-1.
   always @(posedge clk) begin
      dl[0] <= 8'(a_out + b_out);
      dl[1] <= dl[0];
      dl[2] <= dl[1];
   end

   always_comb begin
      case (mode)
         1:       sum_in = 8'h00;
         2:       sum_in = dl[1];
         3:       sum_in = dl[2];
         default: sum_in = 8'(a_out + b_out);
      endcase
   end

   assign sum2 = ~8'(a2 + b2);

   adder_stim_checker #(.WIDTH(8), .SETTLE(2), .NUM_VECTORS(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .a_out(a_out), .b_out(b_out), .sum_in(sum_in),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_a(fail_a), .fail_b(fail_b), .fail_sum(fail_sum)
   );

   adder_stim_checker #(.WIDTH(8), .SETTLE(2), .NUM_VECTORS(300)) u_sat (
      .clk(clk), .rst(rst), .start(start2), .a_out(a2), .b_out(b2), .sum_in(sum2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .fail_a(fa2), .fail_b(fb2), .fail_sum(fs2)
   );

   // Leaves the bench at cycle 1 (the DRIVE cycle) of the new run.
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Returns the cycle number (cycle 1 = DRIVE) at which done is first seen.
   task automatic wait_done(input int limit, output int cyc, output bit ok);
      cyc = 1;
      ok  = 1'b0;
      while (cyc <= limit) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; start2 = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, pass} !== 3'b000) begin
         failures++; $display("FAIL reset_flags busy/done/pass=%b expected 000", {busy, done, pass});
      end
      checks++;
      if ({a_out, b_out, err_count} !== 24'h0) begin
         failures++; $display("FAIL reset_regs a=%h b=%h err=%h expected 0", a_out, b_out, err_count);
      end
      checks++;
      if ({fail_a, fail_b, fail_sum} !== 24'h0) begin
         failures++; $display("FAIL reset_capture %h %h %h expected 0", fail_a, fail_b, fail_sum);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL rst_over_start busy=%b expected 0", busy);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_golden();
      mode = 0;
      pulse_start();
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL golden_busy busy=%b expected 1", busy);
      end
      @(negedge clk);
      checks++;
      if ({a_out, b_out} !== 16'hE1AC) begin
         failures++; $display("FAIL golden_vec0 a=%h b=%h expected e1 ac", a_out, b_out);
      end
      repeat (4) @(negedge clk);
      checks++;
      if ({a_out, b_out} !== 16'hC359) begin
         failures++; $display("FAIL golden_vec1 a=%h b=%h expected c3 59", a_out, b_out);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         failures++; $display("FAIL golden_done_early done=%b at cycle 16 expected 0", done);
      end
      @(negedge clk);
      checks++;
      if ({done, pass, busy} !== 3'b110 || err_count !== 8'd0) begin
         failures++;
         $display("FAIL golden_done cycle17 done=%b pass=%b busy=%b err=%0d expected 1 1 0 0",
                  done, pass, busy, err_count);
      end
      checks++;
      if ({a_out, b_out} !== 16'h0F67) begin
         failures++; $display("FAIL golden_hold a=%h b=%h expected 0f 67", a_out, b_out);
      end
   endtask

   task automatic test_stuck();
      int  cyc;
      bit  ok;
      mode = 1;
      pulse_start();
      wait_done(60, cyc, ok);
      checks++;
      if (!ok || err_count !== 8'd4 || pass !== 1'b0) begin
         failures++; $display("FAIL stuck_count ok=%0d err=%0d pass=%b expected 1 4 0", ok, err_count, pass);
      end
`ifdef ADDER_CHK_FAIL_CAPTURE_EN
      checks++;
      if ({fail_a, fail_b, fail_sum} !== 24'hE1AC00) begin
         failures++; $display("FAIL stuck_capture %h %h %h expected e1 ac 00", fail_a, fail_b, fail_sum);
      end
`else
      checks++;
      if ({fail_a, fail_b, fail_sum} !== 24'h0) begin
         failures++; $display("FAIL stuck_capture_off %h %h %h expected 0", fail_a, fail_b, fail_sum);
      end
`endif
   endtask

   task automatic test_start_while_busy();
      int  cyc;
      bit  ok;
      mode  = 1;
      start = 1'b1;
      @(negedge clk);
      wait_done(60, cyc, ok);
      start = 1'b0;
      checks++;
      if (!ok || cyc != 17) begin
         failures++; $display("FAIL held_start_done ok=%0d cycle=%0d expected done at 17", ok, cyc);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({done, busy} !== 2'b10 || err_count !== 8'd4) begin
         failures++; $display("FAIL held_start_single done=%b busy=%b err=%0d expected 1 0 4", done, busy, err_count);
      end
      mode = 0;
      pulse_start();
      checks++;
      if (busy !== 1'b1 || err_count !== 8'd0) begin
         failures++; $display("FAIL restart_clear busy=%b err=%0d expected 1 0", busy, err_count);
      end
      wait_done(60, cyc, ok);
      checks++;
      if (!ok || pass !== 1'b1) begin
         failures++; $display("FAIL restart_pass ok=%0d pass=%b expected 1 1", ok, pass);
      end
   endtask

   task automatic test_reset_mid_run();
      int  cyc;
      bit  ok;
      mode = 1;
      pulse_start();
      repeat (9) @(negedge clk);
      checks++;
      if (err_count !== 8'd2 || busy !== 1'b1) begin
         failures++; $display("FAIL midrun_pre err=%0d busy=%b expected 2 1", err_count, busy);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, pass} !== 3'b000 || {a_out, b_out, err_count} !== 24'h0 ||
          {fail_a, fail_b, fail_sum} !== 24'h0) begin
         failures++;
         $display("FAIL midrun_reset busy=%b done=%b pass=%b a=%h b=%h err=%h fa=%h expected all 0",
                  busy, done, pass, a_out, b_out, err_count, fail_a);
      end
      mode = 0;
      pulse_start();
      @(negedge clk);
      checks++;
      if ({a_out, b_out} !== 16'hE1AC) begin
         failures++; $display("FAIL midrun_restart a=%h b=%h expected e1 ac", a_out, b_out);
      end
      wait_done(60, cyc, ok);
      checks++;
      if (!ok || pass !== 1'b1) begin
         failures++; $display("FAIL midrun_finish ok=%0d pass=%b expected 1 1", ok, pass);
      end
   endtask

   task automatic test_saturation();
      int cyc = 0;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      while (!done2 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (done2 !== 1'b1 || err2 !== 8'd255 || pass2 !== 1'b0) begin
         failures++; $display("FAIL saturation done=%b err=%0d pass=%b expected 1 255 0", done2, err2, pass2);
      end
   endtask

   task automatic test_late_settle();
      int  cyc;
      bit  ok;
      mode = 3;
      pulse_start();
      wait_done(60, cyc, ok);
      checks++;
      if (!ok || err_count !== 8'd4 || pass !== 1'b0) begin
         failures++; $display("FAIL late_settle_slow ok=%0d err=%0d pass=%b expected 1 4 0", ok, err_count, pass);
      end
      mode = 2;
      pulse_start();
      wait_done(60, cyc, ok);
      checks++;
      if (!ok || err_count !== 8'd0 || pass !== 1'b1) begin
         failures++; $display("FAIL late_settle_edge ok=%0d err=%0d pass=%b expected 1 0 1", ok, err_count, pass);
      end
   endtask

   initial begin
      test_reset();
      test_golden();
      test_stuck();
      test_start_while_busy();
      test_reset_mid_run();
      test_saturation();
      test_late_settle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
